// File: rtl/button_pkg.sv
// Shared types and constants for the button press classifier and its timebase.
package button_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, HOLD} btn_state_t;

  localparam int MS_PER_S = 1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond timebase: a prescaler counting 0..CPM-1 that flags the wrap cycle.
module ms_tick #(
  parameter int CPM = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (CPM > 1) ? $clog2(CPM) : 1;
  localparam logic [PW-1:0] LAST = PW'(CPM - 1);

  logic [PW-1:0] cnt;

  // Combinational so the consumer can act on the wrap in the same cycle.
  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced presses as short, long or auto-repeat; emits one-cycle pulses.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int LONG_MS    = 5000,
  parameter int REPEAT_MS  = 500,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_onup,
  input  logic btn_ondn,
  output logic short_press,
  output logic long_press,
  output logic repeat_press,
  output logic pressed
);

  localparam int CPM = CLK_HZ / MS_PER_S;
  localparam int MS_MAX = max_int(LONG_MS, REPEAT_MS);
  localparam int MSW = $clog2(MS_MAX + 1);
  localparam logic [MSW-1:0] LONG_LAST = MSW'(LONG_MS - 1);
  localparam logic [MSW-1:0] REP_LAST  = MSW'((REPEAT_MS == 0) ? 0 : REPEAT_MS - 1);

  btn_state_t     state;
  logic [MSW-1:0] ms_cnt;
  logic           tick;
  logic           both;
  logic           press_ev;
  logic           rel_ev;
  logic           clr;
  logic           en;

  // Simultaneous edges cannot come from a sane debouncer; drop both.
  assign both     = btn_onup & btn_ondn;
  assign press_ev = (ACTIVE_LOW ? btn_ondn : btn_onup) & ~both;
  assign rel_ev   = (ACTIVE_LOW ? btn_onup : btn_ondn) & ~both;

  assign clr = (state == IDLE) && press_ev;
  assign en  = (state != IDLE);

  ms_tick #(.CPM(CPM)) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ms_cnt       <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
      pressed      <= 1'b0;
    end else begin
      // NOTE: event pulses default low at the top of the block, so each lasts
      // exactly one cycle and no path leaves them unassigned.
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press_ev) begin
            ms_cnt  <= '0;
            state   <= PRESS;
            pressed <= 1'b1;
          end
        end
        PRESS: begin
          // Release is checked first so it beats a coincident threshold.
          if (rel_ev) begin
            short_press <= 1'b1;
            state       <= IDLE;
            pressed     <= 1'b0;
          end else if (tick) begin
            if (ms_cnt == LONG_LAST) begin
              long_press <= 1'b1;
              ms_cnt     <= '0;
              state      <= HOLD;
            end else begin
              ms_cnt <= ms_cnt + MSW'(1);
            end
          end
        end
        HOLD: begin
          if (rel_ev) begin
            state   <= IDLE;
            pressed <= 1'b0;
          end else if (tick && (REPEAT_MS != 0)) begin
            if (ms_cnt == REP_LAST) begin
              repeat_press <= 1'b1;
              ms_cnt       <= '0;
            end else begin
              ms_cnt <= ms_cnt + MSW'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule
